ixu_execute: RTL and testbench

- Integer execution unit (IXU) stage directly downstream of IXU decode, one instance per integer VLIW slot.
- Consumes decoded op code, operand values and destination index; computes the ALU result.
- Two-stage pipeline (EX, WB): EX registers operands, WB registers result and drives the register-file write port.
- Global stall and flush; retired-op counter for perf.

---
 rtl/ixu_pkg.sv | 39 +++
 rtl/ixu_alu.sv | 35 +++
 rtl/ixu_execute.sv | 113 +++++++++++
 tb/tb_ixu_execute.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ixu_pkg.sv
// Shared definitions for the integer execute stage: op encodings, default widths
// and the EX/WB pipeline register layouts.
package ixu_pkg;

    localparam int IXU_XLEN   = 32;
    localparam int IXU_REG_AW = 5;
    localparam int IXU_CNT_W  = 32;

    localparam logic [4:0] IXU_OP_ADD     = 5'd0;
    localparam logic [4:0] IXU_OP_SUB     = 5'd1;
    localparam logic [4:0] IXU_OP_XOR     = 5'd2;
    localparam logic [4:0] IXU_OP_OR      = 5'd3;
    localparam logic [4:0] IXU_OP_AND     = 5'd4;
    localparam logic [4:0] IXU_OP_SLL     = 5'd5;
    localparam logic [4:0] IXU_OP_SRL     = 5'd6;
    localparam logic [4:0] IXU_OP_SRA     = 5'd7;
    localparam logic [4:0] IXU_OP_SLT     = 5'd8;
    localparam logic [4:0] IXU_OP_SLTU    = 5'd9;
    localparam logic [4:0] IXU_OP_ILLEGAL = 5'h0F;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            op;
        logic                  is_imm;
        logic [IXU_XLEN-1:0]   a;
        logic [IXU_XLEN-1:0]   b;
        logic [IXU_REG_AW-1:0] rs1_idx;
        logic [IXU_REG_AW-1:0] rs2_idx;
        logic [IXU_REG_AW-1:0] rd;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic [IXU_REG_AW-1:0] rd;
        logic [IXU_XLEN-1:0]   data;
    } wb_stage_t;

endpackage

// File: rtl/ixu_alu.sv
// Combinational integer ALU. Unknown op codes report illegal and yield zero.
module ixu_alu
    import ixu_pkg::*;
#(
    parameter int XLEN = IXU_XLEN
) (
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_i)
            IXU_OP_ADD:  result_o = a_i + b_i;
            IXU_OP_SUB:  result_o = a_i - b_i;
            IXU_OP_XOR:  result_o = a_i ^ b_i;
            IXU_OP_OR:   result_o = a_i | b_i;
            IXU_OP_AND:  result_o = a_i & b_i;
            IXU_OP_SLL:  result_o = a_i << shamt;
            IXU_OP_SRL:  result_o = a_i >> shamt;
            IXU_OP_SRA:  result_o = $signed(a_i) >>> shamt;
            IXU_OP_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            IXU_OP_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ixu_execute.sv
// Integer execute slot: EX operand register, WB result register, retire counter.
// Define IXU_FWD_EN to bypass the WB result into EX operands.
module ixu_execute
    import ixu_pkg::*;
#(
    parameter int XLEN   = IXU_XLEN,
    parameter int REG_AW = IXU_REG_AW,
    parameter int CNT_W  = IXU_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op,
    input  logic              is_imm_type,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [11:0]       imm,
    input  logic [REG_AW-1:0] rs1_idx,
    input  logic [REG_AW-1:0] rs2_idx,
    input  logic [REG_AW-1:0] rd,
    input  logic              stall_in,
    input  logic              flush,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  retired_cnt
);

    ex_stage_t        ex_q, ex_d;
    wb_stage_t        wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  op_a, op_b, alu_result;
    logic             alu_illegal;

    // SUB has no immediate form; fold that case into the illegal encoding at capture.
    always_comb begin
        ex_d = ex_q;
        if (!stall_in) begin
            ex_d.valid = in_valid;
            if (in_valid) begin
                ex_d.op      = (op == IXU_OP_SUB && is_imm_type) ? IXU_OP_ILLEGAL : op;
                ex_d.is_imm  = is_imm_type;
                ex_d.a       = rs1_val;
                ex_d.b       = is_imm_type ? {{(XLEN-12){imm[11]}}, imm} : rs2_val;
                ex_d.rs1_idx = rs1_idx;
                ex_d.rs2_idx = rs2_idx;
                ex_d.rd      = rd;
            end
        end
        if (flush) ex_d.valid = 1'b0;
    end

`ifdef IXU_FWD_EN
    logic wb_fwd_ok;
    assign wb_fwd_ok = wb_q.valid && !wb_q.illegal && (wb_q.rd != '0);
    assign op_a = (wb_fwd_ok && wb_q.rd == ex_q.rs1_idx) ? wb_q.data : ex_q.a;
    assign op_b = (wb_fwd_ok && !ex_q.is_imm && wb_q.rd == ex_q.rs2_idx) ? wb_q.data : ex_q.b;
`else
    logic unused_fwd_fields;
    assign unused_fwd_fields = ^{ex_q.rs1_idx, ex_q.rs2_idx, ex_q.is_imm};
    assign op_a = ex_q.a;
    assign op_b = ex_q.b;
`endif

    ixu_alu #(.XLEN(XLEN)) u_alu (
        .op_i      (ex_q.op),
        .a_i       (op_a),
        .b_i       (op_b),
        .result_o  (alu_result),
        .illegal_o (alu_illegal)
    );

    always_comb begin
        wb_d = wb_q;
        if (!stall_in) begin
            wb_d.valid   = ex_q.valid;
            wb_d.illegal = alu_illegal;
            wb_d.rd      = ex_q.rd;
            wb_d.data    = alu_illegal ? '0 : alu_result;
        end
        if (flush) wb_d.valid = 1'b0;
    end

    // An op retires on the edge it leaves WB; a flush on that edge cancels it.
    always_comb begin
        cnt_d = cnt_q;
        if (!flush && !stall_in && wb_q.valid && !wb_q.illegal)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready    = !stall_in;
    assign wb_en       = wb_q.valid && !wb_q.illegal && (wb_q.rd != '0);
    assign wb_rd       = wb_q.rd;
    assign wb_data     = wb_q.data;
    assign illegal_op  = wb_q.valid && wb_q.illegal;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ixu_execute.sv
// Directed bench for ixu_execute (counter built 4 bits wide to reach the wrap).
module tb_ixu_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic        is_imm_type;
    logic [31:0] rs1_val, rs2_val;
    logic [11:0] imm;
    logic [4:0]  rs1_idx, rs2_idx, rd;
    logic        stall_in, flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_op;
    logic [3:0]  retired_cnt;

    int checks = 0;
    int failures = 0;

    ixu_execute #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_imm_type(is_imm_type), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .imm(imm), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd(rd),
        .stall_in(stall_in), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal_op(illegal_op), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] o, input logic it, input logic [31:0] a,
                         input logic [31:0] b, input logic [11:0] im, input logic [4:0] r);
        in_valid = 1'b1; op = o; is_imm_type = it; rs1_val = a; rs2_val = b;
        imm = im; rd = r; rs1_idx = 5'd0; rs2_idx = 5'd0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
        issue(5'd0, 1'b0, 32'd1, 32'd2, 12'd0, 5'd1);
        repeat (3) tick();
        checks++;
        if ({wb_en, wb_data, retired_cnt, illegal_op} !== {1'b0, 32'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got en=%b data=%h cnt=%0d ill=%b exp 0/0/0/0",
                     wb_en, wb_data, retired_cnt, illegal_op);
        end
        rst_n = 1'b1; idle();
        tick();
        checks++;
        if (wb_en !== 1'b0) begin
            failures++; $display("FAIL reset_release_en got=%b exp=0", wb_en);
        end
    endtask

    task automatic test_back_to_back();
        issue(5'd0, 1'b0, 32'd5, 32'd7, 12'd0, 5'd1);          tick();
        issue(5'd1, 1'b0, 32'd5, 32'd7, 12'd0, 5'd2);          tick();
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd1, 32'd12}) begin
            failures++; $display("FAIL b2b_add got en=%b rd=%0d data=%h exp 1/1/0000000c", wb_en, wb_rd, wb_data);
        end
        issue(5'd7, 1'b0, 32'h8000_0000, 32'd4, 12'd0, 5'd3);  tick();
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd2, 32'hFFFF_FFFE}) begin
            failures++; $display("FAIL b2b_sub got en=%b rd=%0d data=%h exp 1/2/fffffffe", wb_en, wb_rd, wb_data);
        end
        issue(5'd9, 1'b0, 32'd1, 32'hFFFF_FFFF, 12'd0, 5'd4);  tick();
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd3, 32'hF800_0000}) begin
            failures++; $display("FAIL b2b_sra got en=%b rd=%0d data=%h exp 1/3/f8000000", wb_en, wb_rd, wb_data);
        end
        idle(); tick();
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd4, 32'd1}) begin
            failures++; $display("FAIL b2b_sltu got en=%b rd=%0d data=%h exp 1/4/00000001", wb_en, wb_rd, wb_data);
        end
        tick();
        checks++;
        if ({wb_en, retired_cnt} !== {1'b0, 4'd4}) begin
            failures++; $display("FAIL b2b_drain got en=%b cnt=%0d exp 0/4", wb_en, retired_cnt);
        end
    endtask

    task automatic test_misc_ops();
        issue(5'd8, 1'b0, 32'hFFFF_FFFF, 32'd1, 12'd0, 5'd10); tick();
        issue(5'd5, 1'b0, 32'd1, 32'h0000_003F, 12'd0, 5'd11); tick();
        checks++;
        if ({wb_rd, wb_data} !== {5'd10, 32'd1}) begin
            failures++; $display("FAIL slt_signed got rd=%0d data=%h exp 10/00000001", wb_rd, wb_data);
        end
        issue(5'd6, 1'b0, 32'h8000_0000, 32'd31, 12'd0, 5'd12); tick();
        checks++;
        if ({wb_rd, wb_data} !== {5'd11, 32'h8000_0000}) begin
            failures++; $display("FAIL sll_shamt got rd=%0d data=%h exp 11/80000000", wb_rd, wb_data);
        end
        issue(5'd4, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 12'd0, 5'd13); tick();
        checks++;
        if ({wb_rd, wb_data} !== {5'd12, 32'd1}) begin
            failures++; $display("FAIL srl got rd=%0d data=%h exp 12/00000001", wb_rd, wb_data);
        end
        idle(); tick();
        checks++;
        if ({wb_rd, wb_data} !== {5'd13, 32'h0000_F000}) begin
            failures++; $display("FAIL and got rd=%0d data=%h exp 13/0000f000", wb_rd, wb_data);
        end
        tick();
        checks++;
        if (retired_cnt !== 4'd8) begin
            failures++; $display("FAIL misc_cnt got=%0d exp=8", retired_cnt);
        end
    endtask

    task automatic test_stall_flush();
        issue(5'd0, 1'b1, 32'd10, 32'd0, 12'hFFF, 5'd5);         tick();
        issue(5'd2, 1'b0, 32'h0000_00F0, 32'h0000_000F, 12'd0, 5'd6); tick();
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'd9}) begin
            failures++; $display("FAIL addi_neg got en=%b rd=%0d data=%h exp 1/5/00000009", wb_en, wb_rd, wb_data);
        end
        issue(5'd3, 1'b0, 32'h0000_0100, 32'd1, 12'd0, 5'd7);
        stall_in = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL in_ready_stall got=%b exp=0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({wb_en, wb_rd, wb_data, retired_cnt} !== {1'b1, 5'd5, 32'd9, 4'd8}) begin
                failures++; $display("FAIL stall_hold[%0d] got en=%b rd=%0d data=%h cnt=%0d exp 1/5/00000009/8",
                                     i, wb_en, wb_rd, wb_data, retired_cnt);
            end
        end
        stall_in = 1'b0;
        tick();
        checks++;
        if ({wb_en, wb_rd, wb_data, retired_cnt} !== {1'b1, 5'd6, 32'h0000_00FF, 4'd9}) begin
            failures++; $display("FAIL after_stall got en=%b rd=%0d data=%h cnt=%0d exp 1/6/000000ff/9",
                                 wb_en, wb_rd, wb_data, retired_cnt);
        end
        issue(5'd0, 1'b0, 32'd1, 32'd1, 12'd0, 5'd8); tick();
        checks++;
        if ({wb_en, wb_rd, wb_data, retired_cnt} !== {1'b1, 5'd7, 32'h0000_0101, 4'd10}) begin
            failures++; $display("FAIL after_stall_or got en=%b rd=%0d data=%h cnt=%0d exp 1/7/00000101/10",
                                 wb_en, wb_rd, wb_data, retired_cnt);
        end
        idle(); stall_in = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if ({wb_en, retired_cnt} !== {1'b0, 4'd10}) begin
            failures++; $display("FAIL flush_stall got en=%b cnt=%0d exp 0/10", wb_en, retired_cnt);
        end
        stall_in = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if ({wb_en, retired_cnt} !== {1'b0, 4'd10}) begin
            failures++; $display("FAIL flush_kill_ex got en=%b cnt=%0d exp 0/10", wb_en, retired_cnt);
        end
    endtask

    task automatic test_illegal();
        issue(5'd1, 1'b1, 32'd9, 32'd0, 12'd1, 5'd9); tick();
        idle(); tick();
        checks++;
        if ({illegal_op, wb_en, wb_data} !== {1'b1, 1'b0, 32'd0}) begin
            failures++; $display("FAIL subi_illegal got ill=%b en=%b data=%h exp 1/0/0", illegal_op, wb_en, wb_data);
        end
        tick();
        checks++;
        if ({illegal_op, retired_cnt} !== {1'b0, 4'd10}) begin
            failures++; $display("FAIL subi_pulse got ill=%b cnt=%0d exp 0/10", illegal_op, retired_cnt);
        end
        issue(5'd12, 1'b0, 32'd9, 32'd9, 12'd0, 5'd9); tick();
        idle(); tick();
        checks++;
        if ({illegal_op, wb_en, wb_data} !== {1'b1, 1'b0, 32'd0}) begin
            failures++; $display("FAIL op12_illegal got ill=%b en=%b data=%h exp 1/0/0", illegal_op, wb_en, wb_data);
        end
        tick();
        checks++;
        if ({illegal_op, retired_cnt} !== {1'b0, 4'd10}) begin
            failures++; $display("FAIL op12_pulse got ill=%b cnt=%0d exp 0/10", illegal_op, retired_cnt);
        end
        issue(5'd0, 1'b0, 32'd2, 32'd3, 12'd0, 5'd0); tick();
        idle(); tick();
        checks++;
        if ({illegal_op, wb_en, wb_data} !== {1'b0, 1'b0, 32'd5}) begin
            failures++; $display("FAIL rd0_noen got ill=%b en=%b data=%h exp 0/0/5", illegal_op, wb_en, wb_data);
        end
        tick();
        checks++;
        if (retired_cnt !== 4'd11) begin
            failures++; $display("FAIL rd0_retire got=%0d exp=11", retired_cnt);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp2;
`ifdef IXU_FWD_EN
        exp2 = 32'd8;
`else
        exp2 = 32'd1;
`endif
        issue(5'd0, 1'b0, 32'd3, 32'd4, 12'd0, 5'd1); tick();
        issue(5'd0, 1'b1, 32'd0, 32'd0, 12'd1, 5'd2); rs1_idx = 5'd1; tick();
        checks++;
        if ({wb_rd, wb_data} !== {5'd1, 32'd7}) begin
            failures++; $display("FAIL fwd_producer got rd=%0d data=%h exp 1/00000007", wb_rd, wb_data);
        end
        idle(); tick();
        checks++;
        if ({wb_rd, wb_data} !== {5'd2, exp2}) begin
            failures++; $display("FAIL fwd_consumer got rd=%0d data=%h exp 2/%h", wb_rd, wb_data, exp2);
        end
        tick();
        checks++;
        if (retired_cnt !== 4'd13) begin
            failures++; $display("FAIL fwd_cnt got=%0d exp=13", retired_cnt);
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        issue(5'd0, 1'b0, 32'd1, 32'd1, 12'd0, 5'd3); tick();
        idle(); rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        checks++;
        if ({wb_en, retired_cnt} !== {1'b0, 4'd0}) begin
            failures++; $display("FAIL reset_mid got en=%b cnt=%0d exp 0/0", wb_en, retired_cnt);
        end
        for (int i = 0; i < 15; i++) begin
            issue(5'd0, 1'b0, i, 32'd1, 12'd0, 5'd1); tick();
        end
        idle(); tick(); tick();
        checks++;
        if (retired_cnt !== 4'd15) begin
            failures++; $display("FAIL cnt_max got=%0d exp=15", retired_cnt);
        end
        issue(5'd0, 1'b0, 32'd0, 32'd0, 12'd0, 5'd1); tick();
        idle(); tick(); tick();
        checks++;
        if (retired_cnt !== 4'd0) begin
            failures++; $display("FAIL cnt_wrap got=%0d exp=0", retired_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 5'd0; is_imm_type = 1'b0;
        rs1_val = '0; rs2_val = '0; imm = '0; rs1_idx = '0; rs2_idx = '0; rd = '0;
        stall_in = 1'b0; flush = 1'b0;
        test_reset();
        test_back_to_back();
        test_misc_ops();
        test_stall_flush();
        test_illegal();
        test_forwarding();
        test_reset_mid_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
